// File: rtl/operand_stage_if.sv
// Operand stage bus: decode-side offer, register-file writeback, flush,
// and the registered execute-side outputs.
interface operand_stage_if;
    // Decode side
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic        id_use_pc;
    logic [31:0] id_pc;
    // Register-file write port
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    // Pipeline control
    logic        flush;
    // Execute side
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_rd;

    // Environment view: drives decode, writeback, flush and ex_ready
    modport master (
        output id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_imm,
               id_use_imm, id_use_pc, id_pc,
               wb_en, wb_rd, wb_data, flush, ex_ready,
        input  id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_rd
    );

    // Stage view
    modport slave (
        input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_imm,
               id_use_imm, id_use_pc, id_pc,
               wb_en, wb_rd, wb_data, flush, ex_ready,
        output id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_rd
    );
endinterface

// File: rtl/operand_stage.sv
// Operand fetch stage: 32x32 register file with write bypass, operand
// selection, and a single-entry valid/ready pipeline register towards execute.
module operand_stage (
    input  logic            clk,
    input  logic            rst_n,
    operand_stage_if.slave  bus
);

    // Storage for x1..x31; x0 is hardwired to zero and has no storage.
    logic [31:0] r_regs [1:31];
    // Read view of the whole file, index 0 included.
    logic [31:0] w_rf_word [32];

    logic        w_wb_write;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_in1;
    logic [31:0] w_in2;
    logic        w_id_ready;
    logic        w_load;
    logic        w_ex_valid_next;

    logic        r_ex_valid;
    logic [3:0]  r_ex_alu_op;
    logic [31:0] r_ex_in1;
    logic [31:0] r_ex_in2;
    logic [4:0]  r_ex_rd;

    // A write to x0 is never a real write, neither for storage nor bypass.
    assign w_wb_write = bus.wb_en && (bus.wb_rd != 5'd0);

    assign w_rf_word[0] = 32'd0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_rf
            // Register entry: cleared by reset, written whenever addressed,
            // independent of flush, hold or valid state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= 32'd0;
                end else if (w_wb_write && (bus.wb_rd == 5'(gi))) begin
                    r_regs[gi] <= bus.wb_data;
                end
            end

            assign w_rf_word[gi] = r_regs[gi];
        end
    endgenerate

    // Source reads with same-cycle writeback bypass (x0 never bypassed).
    always_comb begin
        w_rs1_data = w_rf_word[bus.id_rs1];
        w_rs2_data = w_rf_word[bus.id_rs2];
        if (w_wb_write && (bus.wb_rd == bus.id_rs1)) begin
            w_rs1_data = bus.wb_data;
        end
        if (w_wb_write && (bus.wb_rd == bus.id_rs2)) begin
            w_rs2_data = bus.wb_data;
        end
    end

    // Operand selection: plain muxes, no arithmetic.
    assign w_in1 = bus.id_use_pc  ? bus.id_pc  : w_rs1_data;
    assign w_in2 = bus.id_use_imm ? bus.id_imm : w_rs2_data;

    // Stage can take a new instruction when empty or when the held one leaves.
    assign w_id_ready = !r_ex_valid || bus.ex_ready;
    assign w_load     = bus.id_valid && w_id_ready && !bus.flush;

    // Valid next-state: flush wins, then load, then drain, else hold.
    always_comb begin
        w_ex_valid_next = r_ex_valid;
        if (bus.flush) begin
            w_ex_valid_next = 1'b0;
        end else if (w_load) begin
            w_ex_valid_next = 1'b1;
        end else if (r_ex_valid && bus.ex_ready) begin
            w_ex_valid_next = 1'b0;
        end
    end

    // Pipeline register: valid follows the handshake, data only moves on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_alu_op <= 4'd0;
            r_ex_in1    <= 32'd0;
            r_ex_in2    <= 32'd0;
            r_ex_rd     <= 5'd0;
        end else begin
            r_ex_valid <= w_ex_valid_next;
            if (w_load) begin
                r_ex_alu_op <= bus.id_alu_op;
                r_ex_in1    <= w_in1;
                r_ex_in2    <= w_in2;
                r_ex_rd     <= bus.id_rd;
            end
        end
    end

    assign bus.id_ready  = w_id_ready;
    assign bus.ex_valid  = r_ex_valid;
    assign bus.ex_alu_op = r_ex_alu_op;
    assign bus.ex_in1    = r_ex_in1;
    assign bus.ex_in2    = r_ex_in2;
    assign bus.ex_rd     = r_ex_rd;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: table-driven single-cycle loads plus
// hand-written stall, hold, flush and reset sequences.
module tb_operand_stage;

    logic clk;
    logic rst_n;

    operand_stage_if bus ();

    operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_pc;
        logic        use_imm;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
    } vec_t;

    vec_t vecs [8];

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.id_valid   = 1'b0;
        bus.id_alu_op  = 4'd0;
        bus.id_rs1     = 5'd0;
        bus.id_rs2     = 5'd0;
        bus.id_rd      = 5'd0;
        bus.id_imm     = 32'd0;
        bus.id_use_imm = 1'b0;
        bus.id_use_pc  = 1'b0;
        bus.id_pc      = 32'd0;
        bus.wb_en      = 1'b0;
        bus.wb_rd      = 5'd0;
        bus.wb_data    = 32'd0;
        bus.flush      = 1'b0;
        bus.ex_ready   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int got;
        logic hold_pending;
        logic [31:0] hold_in2;
        logic [4:0] hold_rd;
        logic load_now;

        n_tests = 0;
        n_fail  = 0;

        //         op    rs1    rs2    rd     pc  imm  pc           imm           wb wb_rd  wb_data        e_in1          e_in2
        vecs[0] = '{4'h1, 5'd1,  5'd0,  5'd10, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0};
        vecs[1] = '{4'h2, 5'd5,  5'd0,  5'd11, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 5'd0,  32'h0,         32'h0000_1234, 32'h0};
        vecs[2] = '{4'h3, 5'd7,  5'd5,  5'd12, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[3] = '{4'h4, 5'd0,  5'd0,  5'd13, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[4] = '{4'h5, 5'd0,  5'd7,  5'd14, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 5'd0,  32'h0,         32'h0,         32'hDEAD_BEEF};
        vecs[5] = '{4'h6, 5'd5,  5'd5,  5'd15, 1'b1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0, 32'h0000_0400, 32'hFFFF_FFFC};
        vecs[6] = '{4'hA, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 5'd31, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[7] = '{4'hF, 5'd31, 5'd2,  5'd1,  1'b0, 1'b1, 32'h0, 32'h0000_0007, 1'b0, 5'd0, 32'h0,         32'hA5A5_5A5A, 32'h0000_0007};

        // ---------------- Reset state ----------------
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_alu_op", 32'(bus.ex_alu_op), 32'd0);
        chk("rst_ex_in1", bus.ex_in1, 32'd0);
        chk("rst_ex_in2", bus.ex_in2, 32'd0);
        chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
        $display("[TB] reset: ex_valid=%0b id_ready=%0b", bus.ex_valid, bus.id_ready);
        rst_n = 1'b1;

        // ---------------- Table-driven loads, ex_ready=1 ----------------
        for (int i = 0; i < 8; i++) begin
            bus.id_valid   = 1'b1;
            bus.id_alu_op  = vecs[i].op;
            bus.id_rs1     = vecs[i].rs1;
            bus.id_rs2     = vecs[i].rs2;
            bus.id_rd      = vecs[i].rd;
            bus.id_use_pc  = vecs[i].use_pc;
            bus.id_use_imm = vecs[i].use_imm;
            bus.id_pc      = vecs[i].pc;
            bus.id_imm     = vecs[i].imm;
            bus.wb_en      = vecs[i].wb_en;
            bus.wb_rd      = vecs[i].wb_rd;
            bus.wb_data    = vecs[i].wb_data;
            bus.ex_ready   = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.ex_valid), 32'd1);
            chk($sformatf("vec%0d_op", i), 32'(bus.ex_alu_op), 32'(vecs[i].op));
            chk($sformatf("vec%0d_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_in1", i), bus.ex_in1, vecs[i].e_in1);
            chk($sformatf("vec%0d_in2", i), bus.ex_in2, vecs[i].e_in2);
            $display("[TB] vec %0d: op=%h rd=%0d in1=%h in2=%h", i, bus.ex_alu_op, bus.ex_rd, bus.ex_in1, bus.ex_in2);
        end
        idle_inputs();

        // Drain with nothing offered
        tick();
        chk("drain_valid", 32'(bus.ex_valid), 32'd0);
        $display("[TB] drain: ex_valid=%0b", bus.ex_valid);

        // ---------------- Hold with writeback to a captured source ----------------
        bus.ex_ready = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_rs1   = 5'd5;
        bus.id_rs2   = 5'd7;
        bus.id_rd    = 5'd3;
        bus.id_alu_op = 4'h9;
        tick();
        chk("hold_load_in1", bus.ex_in1, 32'h0000_1234);
        chk("hold_load_in2", bus.ex_in2, 32'hDEAD_BEEF);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd5;
        bus.wb_data = 32'h0000_0055;
        #1;
        chk("hold_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        bus.wb_en = 1'b0;
        chk("hold_valid", 32'(bus.ex_valid), 32'd1);
        chk("hold_in1_stable", bus.ex_in1, 32'h0000_1234);
        chk("hold_op_stable", 32'(bus.ex_alu_op), 32'h9);
        bus.ex_ready = 1'b1;
        tick();
        chk("hold_reload_in1", bus.ex_in1, 32'h0000_0055);
        $display("[TB] hold/writeback: reloaded in1=%h", bus.ex_in1);
        idle_inputs();
        tick();

        // ---------------- 10-instruction stream with stalls ----------------
        k = 0;
        got = 0;
        hold_pending = 1'b0;
        hold_in2 = 32'd0;
        hold_rd = 5'd0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            bus.ex_ready = !((c >= 2 && c < 5) || c == 8 || c == 9);
            if (k < 10) begin
                bus.id_valid   = 1'b1;
                bus.id_use_pc  = 1'b1;
                bus.id_use_imm = 1'b1;
                bus.id_pc      = 32'h0000_1000 + 32'(4 * k);
                bus.id_imm     = 32'(100 + k);
                bus.id_rd      = 5'(k);
                bus.id_alu_op  = 4'(k);
            end else begin
                bus.id_valid = 1'b0;
            end
            #1;
            if (hold_pending) begin
                chk("stream_hold_valid", 32'(bus.ex_valid), 32'd1);
                chk("stream_hold_in2", bus.ex_in2, hold_in2);
                chk("stream_hold_rd", 32'(bus.ex_rd), 32'(hold_rd));
            end
            if (bus.ex_valid && !bus.ex_ready) begin
                chk("stream_stall_id_ready", 32'(bus.id_ready), 32'd0);
            end
            if (!bus.ex_valid || bus.ex_ready) begin
                chk("stream_id_ready", 32'(bus.id_ready), 32'd1);
            end
            if (bus.ex_valid && bus.ex_ready) begin
                chk("stream_in2", bus.ex_in2, 32'(100 + got));
                chk("stream_in1", bus.ex_in1, 32'h0000_1000 + 32'(4 * got));
                $display("[TB] stream consume %0d: rd=%0d in1=%h in2=%h", got, bus.ex_rd, bus.ex_in1, bus.ex_in2);
                got++;
            end
            hold_pending = bus.ex_valid && !bus.ex_ready;
            hold_in2 = bus.ex_in2;
            hold_rd = bus.ex_rd;
            load_now = bus.id_valid && bus.id_ready;
            tick();
            if (load_now) k++;
        end
        chk("stream_count", 32'(got), 32'd10);
        idle_inputs();
        tick();
        chk("stream_empty", 32'(bus.ex_valid), 32'd0);

        // ---------------- Flush ----------------
        // Flush with a load offered to an empty stage: dropped.
        bus.id_valid   = 1'b1;
        bus.id_use_pc  = 1'b1;
        bus.id_pc      = 32'h0000_BEEF;
        bus.flush      = 1'b1;
        #1;
        chk("flush_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk("flush_drop_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_drop_in1", bus.ex_in1, 32'h0000_1000 + 32'(4 * 9));
        $display("[TB] flush drop: ex_valid=%0b in1=%h", bus.ex_valid, bus.ex_in1);
        // Flush of a held instruction.
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        bus.id_pc    = 32'h0000_0800;
        tick();
        chk("flush_pre_valid", 32'(bus.ex_valid), 32'd1);
        chk("flush_pre_in1", bus.ex_in1, 32'h0000_0800);
        bus.flush = 1'b1;
        tick();
        chk("flush_held_valid", 32'(bus.ex_valid), 32'd0);
        $display("[TB] flush held: ex_valid=%0b", bus.ex_valid);
        idle_inputs();

        // ---------------- Asynchronous reset mid-operation ----------------
        bus.ex_ready = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_rs1   = 5'd7;
        bus.id_rs2   = 5'd31;
        tick();
        chk("rst2_pre_valid", 32'(bus.ex_valid), 32'd1);
        chk("rst2_pre_in1", bus.ex_in1, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst2_in1", bus.ex_in1, 32'd0);
        chk("rst2_in2", bus.ex_in2, 32'd0);
        chk("rst2_id_ready", 32'(bus.id_ready), 32'd1);
        $display("[TB] async reset: ex_valid=%0b in1=%h", bus.ex_valid, bus.ex_in1);
        tick();
        rst_n = 1'b1;
        // Register file must have been cleared.
        bus.ex_ready = 1'b1;
        bus.id_rs1   = 5'd7;
        bus.id_rs2   = 5'd31;
        tick();
        chk("rst2_post_valid", 32'(bus.ex_valid), 32'd1);
        chk("rst2_x7_cleared", bus.ex_in1, 32'd0);
        chk("rst2_x31_cleared", bus.ex_in2, 32'd0);
        bus.id_rs1 = 5'd5;
        bus.id_rs2 = 5'd1;
        tick();
        chk("rst2_x5_cleared", bus.ex_in1, 32'd0);
        $display("[TB] post reset read: x7/x31/x5 in1=%h in2=%h", bus.ex_in1, bus.ex_in2);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
